// File: rtl/dta_pkg.sv
// Shared types for the dest-tag-append return scheduler.
// Holds the return header layout and a constant-width helper.
// No logic: types and functions only.
package dta_pkg;

    // Header field widths; the top-level tag/dst/vc parameters must match these.
    localparam int HDR_TAG_W = 8;
    localparam int HDR_DST_W = 4;
    localparam int HDR_VC_W  = 1;

    typedef struct packed {
        logic [HDR_TAG_W-1:0] tag;
        logic [HDR_DST_W-1:0] dst;
        logic [HDR_VC_W-1:0]  vc;
    } ret_hdr_t;

    // Ceiling log2, usable in constant expressions (port widths, localparams).
    function automatic int dta_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dta_hdr_fifo.sv
// In-order FIFO of return headers, first-word-fall-through from registered storage.
// Latency: a push in cycle N is visible at o_head / o_empty from cycle N+1.
// Backpressure: pushes are ignored when full and pops are ignored when empty.
// Ports: clk/rst_n, i_push/i_wr_hdr write side, i_pop read side,
//        o_head oldest entry, o_full/o_empty flags, o_count occupancy.
module dta_hdr_fifo
    import dta_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  ret_hdr_t                   i_wr_hdr,
    input  logic                       i_pop,
    output ret_hdr_t                   o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [dta_clog2(DEPTH):0]  o_count
);

    localparam int            AW       = dta_clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    ret_hdr_t      r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr_en;
    logic          w_rd_en;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop  && !o_empty;

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_hdr;
        end
    end

    // Pointers are exactly AW bits, so they wrap at DEPTH (a power of 2) for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dta_return_scheduler.sv
// Pairs in-order module responses with stored return headers for the return packetizer.
// Latency: request path combinational (0 cycles); response accept to pkt_valid_out 1 cycle.
// Backpressure: requests stall when the header FIFO is full; responses stall when it is
//               empty or the output register is held by pkt_ready_in low.
// Ports: req_* from depacketizer, mod_* to the compute module, rsp_* from the module,
//        pkt_* to the packetizer, outstanding_out = headers held.
module dta_return_scheduler
    import dta_pkg::*;
#(
    parameter int WIDTH_DATA       = 12,
    parameter int WIDTH_RSP        = 12,
    parameter int ADDRESS_WIDTH    = HDR_DST_W,
    parameter int VC_ADDRESS_WIDTH = HDR_VC_W,
    parameter int WIDTH_TAG        = HDR_TAG_W,
    parameter int DEPTH            = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH_DATA-1:0]         req_data_in,
    input  logic [ADDRESS_WIDTH-1:0]      req_dst_in,
    input  logic [VC_ADDRESS_WIDTH-1:0]   req_vc_in,
    input  logic [WIDTH_TAG-1:0]          req_tag_in,
    input  logic                          req_valid_in,
    output logic                          req_ready_out,
    output logic [WIDTH_DATA-1:0]         mod_data_out,
    output logic                          mod_valid_out,
    input  logic                          mod_ready_in,
    input  logic [WIDTH_RSP-1:0]          rsp_data_in,
    input  logic                          rsp_valid_in,
    output logic                          rsp_ready_out,
    output logic [WIDTH_RSP-1:0]          pkt_data_out,
    output logic [ADDRESS_WIDTH-1:0]      pkt_dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0]   pkt_vc_out,
    output logic [WIDTH_TAG-1:0]          pkt_tag_out,
    output logic                          pkt_valid_out,
    input  logic                          pkt_ready_in,
    output logic [dta_clog2(DEPTH):0]     outstanding_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic                         w_full;
    logic                         w_empty;
    logic                         w_push;
    logic                         w_accept;
    ret_hdr_t                     w_wr_hdr;
    ret_hdr_t                     w_head;
    logic [dta_clog2(DEPTH):0]    w_count;

    logic [0:0]                   r_state;
    logic [WIDTH_RSP-1:0]         r_pkt_data;
    logic [ADDRESS_WIDTH-1:0]     r_pkt_dst;
    logic [VC_ADDRESS_WIDTH-1:0]  r_pkt_vc;
    logic [WIDTH_TAG-1:0]         r_pkt_tag;

    // Request pass-through. Full blocks acceptance even if a pop lands in the same
    // cycle, which keeps the response side out of the request-ready timing path.
    assign mod_data_out  = req_data_in;
    assign mod_valid_out = req_valid_in && !w_full;
    assign req_ready_out = mod_ready_in && !w_full;
    assign w_push        = req_valid_in && req_ready_out;

    assign w_wr_hdr.tag  = req_tag_in;
    assign w_wr_hdr.dst  = req_dst_in;
    assign w_wr_hdr.vc   = req_vc_in;

    dta_hdr_fifo #(
        .DEPTH (DEPTH)
    ) u_hdr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_wr_hdr (w_wr_hdr),
        .i_pop    (w_accept),
        .o_head   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    // A response can only be taken when a header is waiting and the output
    // register is free now or is being drained this cycle.
    assign rsp_ready_out = !w_empty && ((r_state == ST_IDLE) || pkt_ready_in);
    assign w_accept      = rsp_valid_in && rsp_ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pkt_data <= '0;
            r_pkt_dst  <= '0;
            r_pkt_vc   <= '0;
            r_pkt_tag  <= '0;
        end else begin
            if (w_accept) begin
                r_state    <= ST_HOLD;
                r_pkt_data <= rsp_data_in;
                r_pkt_dst  <= w_head.dst;
                r_pkt_vc   <= w_head.vc;
                r_pkt_tag  <= w_head.tag;
            end else if (pkt_ready_in) begin
                r_state    <= ST_IDLE;
            end
        end
    end

    assign pkt_valid_out   = (r_state == ST_HOLD);
    assign pkt_data_out    = r_pkt_data;
    assign pkt_dst_out     = r_pkt_dst;
    assign pkt_vc_out      = r_pkt_vc;
    assign pkt_tag_out     = r_pkt_tag;
    assign outstanding_out = w_count;

endmodule

// File: doc/dta_return_scheduler.md
Name: dta_return_scheduler

Overview:
- Sits between the dest-tag-append depacketizer and the user compute module on a slave NoC port.
- Forwards each request payload to the module and stores its return header {tag, dst, vc} in an in-order FIFO.
- Pairs each module response with the oldest stored header and presents header plus response to the return packetizer.
- Sequences the request/response datapath so a stateless module can answer tagged requests in order.

Parameters:
- WIDTH_DATA, 12: request payload width.
- WIDTH_RSP, 12: response payload width.
- ADDRESS_WIDTH, 4: return destination width.
- VC_ADDRESS_WIDTH, 1: return VC width.
- WIDTH_TAG, 8: return tag width.
- DEPTH, 8: maximum outstanding requests. Power of 2, at least 2.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_data_in, input, WIDTH_DATA: request payload from depacketizer.
- req_dst_in, input, ADDRESS_WIDTH: return destination.
- req_vc_in, input, VC_ADDRESS_WIDTH: return VC.
- req_tag_in, input, WIDTH_TAG: return tag.
- req_valid_in, input, 1: request valid.
- req_ready_out, output, 1: request accepted when high together with valid.
- mod_data_out, output, WIDTH_DATA: payload to module.
- mod_valid_out, output, 1: payload valid to module.
- mod_ready_in, input, 1: module ready.
- rsp_data_in, input, WIDTH_RSP: module response.
- rsp_valid_in, input, 1: response valid.
- rsp_ready_out, output, 1: response accepted.
- pkt_data_out, output, WIDTH_RSP: response to packetizer.
- pkt_dst_out, output, ADDRESS_WIDTH: return destination.
- pkt_vc_out, output, VC_ADDRESS_WIDTH: return VC.
- pkt_tag_out, output, WIDTH_TAG: return tag.
- pkt_valid_out, output, 1: return packet valid.
- pkt_ready_in, input, 1: packetizer ready.
- outstanding_out, output, clog2(DEPTH)+1: headers currently held in the FIFO.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers and count go to 0. Output register valid clears, so pkt_valid_out = 0. All pkt_* data outputs go to 0 and outstanding_out = 0. Reset asserted mid-transaction discards all headers and any held response.
- Request path is combinational pass-through, zero latency:
  - mod_data_out = req_data_in.
  - mod_valid_out = req_valid_in && !full.
  - req_ready_out = mod_ready_in && !full.
  - push = req_valid_in && req_ready_out; it writes {tag, dst, vc} at the write pointer.
- full = (count == DEPTH). When full, no request is accepted even if a pop happens in the same cycle. This removes a combinational pop-to-push path.
- Response path uses a 1-entry output register (states IDLE, HOLD):
  - rsp_ready_out = !empty && (!out_valid || pkt_ready_in).
  - accept = rsp_valid_in && rsp_ready_out. On accept the register loads rsp_data_in plus the FIFO head header, out_valid is set, and the FIFO pops.
  - IDLE to HOLD on accept. HOLD to IDLE on pkt_ready_in with no new accept. HOLD stays HOLD on pkt_ready_in with an accept (back-to-back, one packet per cycle).
  - Latency from response accept to pkt_valid_out is 1 cycle.
  - pkt_* outputs are stable while pkt_valid_out && !pkt_ready_in.
- FIFO read is registered-storage first-word-fall-through. A header pushed in cycle N is usable by a response no earlier than cycle N+1; a same-cycle response to an empty FIFO is stalled.
- Empty FIFO: rsp_ready_out = 0. An unmatched response is held off, not dropped.
- Simultaneous push and pop leaves count unchanged.
- Pointers are clog2(DEPTH) bits and wrap naturally. count is tracked separately, clog2(DEPTH)+1 bits.
- outstanding_out = count, registered.
- Ordering: responses are paired strictly FIFO. The module must answer in request order.

Decomposition:
- Shared package dta_pkg:
  - ret_hdr_t packed struct {tag, dst, vc}, parameterized via package localparams matching the defaults.
  - Function for the clog2 helper.
- One natural sub-module, dta_hdr_fifo: synchronous FIFO of ret_hdr_t, DEPTH entries, with push, pop, full, empty, count and head outputs, same clk/rst_n.
- Output register and pass-through logic live in the top.

Test Plan:
- Single round trip: request tag=0x5A dst=3 vc=1 data=0x123 with mod_ready=1. Response 0xABC two cycles later. Expect pkt tag=0x5A, dst=3, vc=1, data=0xABC one cycle after accept, and outstanding 1 then 0.
- Fill: 8 requests with tags 0..7 and no responses. Expect outstanding_out=8 and req_ready_out=0 on the 9th request. Then 8 responses with pkt_ready=1 produce tags 0..7 in order on consecutive cycles.
- Backpressure: pkt_ready_in=0 while a response is held. Expect pkt outputs stable and rsp_ready_out=0 for the next response. Release yields back-to-back packets with no bubble.
- Orphan: rsp_valid=1 with the FIFO empty. Expect rsp_ready_out=0. Push request tag=0x11 in cycle N. Response accepted in cycle N+1 and emitted with tag 0x11.
- Wrap and simultaneous: 20 interleaved requests and responses with random mod_ready and pkt_ready (pointers wrap twice). Scoreboard checks tag order, and count stays unchanged on cycles with both push and pop.
- Reset mid-op: 3 headers outstanding and pkt_valid=1, then assert rst_n=0 asynchronously. Outputs clear immediately, outstanding_out=0, and the next request after release gets a fresh FIFO slot.
